vec_alu_writeback: RTL and testbench
====================================

# vec_alu_writeback

Writeback stage directly downstream of the per-lane vector ALUs. It captures the concatenated lane results and flags of one vector/scalar operation and squashes unused lanes in scalar mode. It reduces lane flags into one architectural flag nibble and presents a lane-masked write to the vector register file through a valid/ready handshake with a 2-entry skid buffer. Sticky overflow/error status is kept for the control unit.

## Interface
- WIDTH, 8, lane data width in bits
- LANES, 4, number of ALU lanes (≥1)
- ADDR_W, 4, register-file destination address width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept (registered)
- in_result  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
- in_flags  in  LANES*4  lane i at [i*4 +: 4]; bit0 C, bit1 Z, bit2 N, bit3 V
- in_opcode  in  3  000 mul, 001 sub, 010 add, 111 set; others illegal
- in_scalar  in  1  1 = only lane 0 meaningful
- in_dest  in  ADDR_W  destination register
- out_valid  out  1  writeback beat valid
- out_ready  in  1  register file accepts
- out_data  out  LANES*WIDTH  lane-squashed result
- out_mask  out  LANES  per-lane write enable
- out_dest  out  ADDR_W  destination register
- out_flags  out  4  reduced flags
- sticky_clr  in  1  clears sticky status
- sticky_ovf  out  1  any accepted beat had out_flags[3]=1
- sticky_err  out  1  any accepted beat had an illegal opcode

## Operation
- Accept on in_valid & in_ready; emit on out_valid & out_ready.
- Processing is done before storage. Entries hold the processed beat.
- Scalar: out_mask=1 on lane 0 only, lanes 1..LANES-1 of out_data forced to 0, so upstream X never propagates. out_flags = lane-0 flags.
- Vector: out_mask all ones. C = OR of lane C. Z = AND of lane Z. N = OR of lane N. V = OR of lane V.
- Illegal opcode: the beat is still accepted and emitted with out_mask=0, out_data=0, out_flags=0. sticky_err is set at accept.
- Sticky bits update at accept. If sticky_clr and a setting accept occur in the same cycle, the set wins.
- Skid buffer states:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on emit without accept.
  - ONE stays ONE on emit with accept.
  - ONE → FULL on accept without emit.
  - FULL → ONE on emit. No accept is possible in FULL.
- Beats leave in strict FIFO order.
- Output regs hold the head entry. The skid entry holds the second entry.

## Timing
- Reset values (async, immediate): state EMPTY, in_ready=1, out_valid=0, out_data=0, out_mask=0, out_dest=0, out_flags=0, sticky_ovf=0, sticky_err=0.
- Latency is 1 cycle: a beat accepted at edge k gives out_valid=1 after edge k when the stage was EMPTY.
- Throughput is 1 beat/cycle while out_ready=1.
- in_ready = (state != FULL), driven from a flop. It has no combinational path from out_ready.
- Output signals are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards both entries. No partial beat is emitted after rst drops.

## Structure
- Shared package vec_pkg holds:
  - opcode constants OP_MUL, OP_SUB, OP_ADD, OP_SET;
  - flag bit indices FLAG_C, FLAG_Z, FLAG_N, FLAG_V;
  - the skid state enum {EMPTY, ONE, FULL}.
- One sub-module, vec_flag_reduce, is combinational. It handles lane squashing, mask and flag reduction, and the illegal-opcode decode.
- The top level holds the skid FSM and the sticky regs.

## Test plan
All cases use WIDTH=8, LANES=4.

1. Vector add, every lane with flags 0010 and results 0, out_ready=1 → next cycle out_valid=1, out_mask=1111, out_flags=0010, out_data=0.
2. Scalar sub, lane0=0x80 with flags 0100, lanes 1-3 driven X → out_data=0x000000_80, out_mask=0001, out_flags=0100.
3. out_ready=0, push beats A, B, C back-to-back → A and B accepted, in_ready=0 after the 2nd accept, C held. Release out_ready → A, B, C emitted in order, one per cycle.
4. Vector mul with lane2 flags 1000 → out_flags[3]=1, sticky_ovf=1 persists. Then assert sticky_clr in the same cycle as another V=1 accept → sticky_ovf stays 1. Then sticky_clr alone → 0.
5. Opcode 011 accepted → out_mask=0000, out_flags=0000, sticky_err=1.
6. Two beats buffered (FULL) and rst pulsed mid-cycle → out_valid=0 and in_ready=1 immediately. No buffered beat appears after release.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU writeback stage: opcodes, flag
// bit positions and the skid-buffer state encoding.
package vec_pkg;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SET = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_SUB) || (op == OP_ADD) || (op == OP_SET);
  endfunction

endpackage

// File: rtl/vec_flag_reduce.sv
// Combinational beat processing: illegal-opcode decode, scalar lane
// squashing, lane write mask and reduction of lane flags into one nibble.
module vec_flag_reduce
  import vec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic [LANES*WIDTH-1:0] result,
  input  logic [LANES*4-1:0]     flags,
  input  logic [2:0]             opcode,
  input  logic                   scalar,
  output logic [LANES*WIDTH-1:0] data,
  output logic [LANES-1:0]       mask,
  output logic [3:0]             flags_out,
  output logic                   illegal
);

  logic red_c, red_z, red_n, red_v;

  // Squash/mask the lanes and reduce flags; illegal beats carry nothing.
  always_comb begin
    data      = '0;
    mask      = '0;
    flags_out = '0;
    illegal   = !is_legal_op(opcode);
    red_c     = 1'b0;
    red_z     = 1'b1;
    red_n     = 1'b0;
    red_v     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      red_c = red_c | flags[i*4+FLAG_C];
      red_z = red_z & flags[i*4+FLAG_Z];
      red_n = red_n | flags[i*4+FLAG_N];
      red_v = red_v | flags[i*4+FLAG_V];
    end
    if (!illegal) begin
      if (scalar) begin
        // Only lane 0 is copied so undriven upper lanes never reach the file.
        data[WIDTH-1:0] = result[WIDTH-1:0];
        mask[0]         = 1'b1;
        flags_out       = flags[3:0];
      end else begin
        data              = result;
        mask              = '1;
        flags_out[FLAG_C] = red_c;
        flags_out[FLAG_Z] = red_z;
        flags_out[FLAG_N] = red_n;
        flags_out[FLAG_V] = red_v;
      end
    end
  end

endmodule

// File: rtl/vec_alu_writeback.sv
// Writeback stage: processes each accepted ALU beat, stores it in a
// 2-entry skid buffer (head = output regs, second = skid entry) and keeps
// sticky overflow/illegal-opcode status for the control unit.
module vec_alu_writeback
  import vec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_result,
  input  logic [LANES*4-1:0]     in_flags,
  input  logic [2:0]             in_opcode,
  input  logic                   in_scalar,
  input  logic [ADDR_W-1:0]      in_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic [ADDR_W-1:0]      out_dest,
  output logic [3:0]             out_flags,
  input  logic                   sticky_clr,
  output logic                   sticky_ovf,
  output logic                   sticky_err
);

  localparam int BEAT_W = LANES*WIDTH + LANES + ADDR_W + 4;

  skid_state_t state, state_next;

  logic [LANES*WIDTH-1:0] proc_data;
  logic [LANES-1:0]       proc_mask;
  logic [3:0]             proc_flags;
  logic                   proc_illegal;
  logic [BEAT_W-1:0]      beat_new, head_q, skid_q;
  logic                   accept, emit;
  logic                   load_head, head_from_skid, load_skid;
  logic                   in_ready_q;

  vec_flag_reduce #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_reduce (
    .result    (in_result),
    .flags     (in_flags),
    .opcode    (in_opcode),
    .scalar    (in_scalar),
    .data      (proc_data),
    .mask      (proc_mask),
    .flags_out (proc_flags),
    .illegal   (proc_illegal)
  );

  assign beat_new  = {proc_data, proc_mask, in_dest, proc_flags};
  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;
  assign {out_data, out_mask, out_dest, out_flags} = head_q;

  // Skid next-state and entry load selection.
  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (emit && accept) begin
          load_head = 1'b1;
        end else if (emit) begin
          state_next = EMPTY;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end
      end
      FULL: begin
        if (emit) begin
          state_next     = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State, registered in_ready and the two buffer entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
      if (load_head) head_q <= head_from_skid ? skid_q : beat_new;
      if (load_skid) skid_q <= beat_new;
    end
  end

  // Sticky status: a set at accept overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      sticky_ovf <= (sticky_ovf & ~sticky_clr) | (accept & proc_flags[FLAG_V]);
      sticky_err <= (sticky_err & ~sticky_clr) | (accept & proc_illegal);
    end
  end

endmodule

// File: tb/tb_vec_alu_writeback.sv
// Directed self-checking bench for vec_alu_writeback (WIDTH=8, LANES=4).
module tb_vec_alu_writeback;

  localparam int WIDTH  = 8;
  localparam int LANES  = 4;
  localparam int ADDR_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_result;
  logic [LANES*4-1:0]     in_flags;
  logic [2:0]             in_opcode;
  logic                   in_scalar;
  logic [ADDR_W-1:0]      in_dest;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_mask;
  logic [ADDR_W-1:0]      out_dest;
  logic [3:0]             out_flags;
  logic                   sticky_clr;
  logic                   sticky_ovf;
  logic                   sticky_err;

  int checks   = 0;
  int failures = 0;

  vec_alu_writeback #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_flags   (in_flags),
    .in_opcode  (in_opcode),
    .in_scalar  (in_scalar),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .out_dest   (out_dest),
    .out_flags  (out_flags),
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
    .sticky_err (sticky_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic sc,
                       input logic [31:0] res, input logic [15:0] fl, input logic [3:0] dst);
    in_valid  = v;
    in_opcode = op;
    in_scalar = sc;
    in_result = res;
    in_flags  = fl;
    in_dest   = dst;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_mask !== 4'h0) begin failures++; $display("FAIL reset_out_mask got=%b exp=0000", out_mask); end
    checks++; if (out_dest !== 4'h0) begin failures++; $display("FAIL reset_out_dest got=%h exp=0", out_dest); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL reset_out_flags got=%b exp=0000", out_flags); end
    checks++; if ({sticky_ovf, sticky_err} !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", {sticky_ovf, sticky_err}); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_vector_add();
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 1'b0, 32'h0, 16'h2222, 4'h5);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL vadd_valid got=%b exp=1", out_valid); end
    checks++; if (out_mask !== 4'b1111) begin failures++; $display("FAIL vadd_mask got=%b exp=1111", out_mask); end
    checks++; if (out_flags !== 4'b0010) begin failures++; $display("FAIL vadd_flags got=%b exp=0010", out_flags); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL vadd_data got=%h exp=00000000", out_data); end
    checks++; if (out_dest !== 4'h5) begin failures++; $display("FAIL vadd_dest got=%h exp=5", out_dest); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vadd_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_scalar_sub();
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 1'b1, 32'hxxxxxx80, 16'hxxx4, 4'h9);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (out_data !== 32'h00000080) begin failures++; $display("FAIL ssub_data got=%h exp=00000080", out_data); end
    checks++; if (out_mask !== 4'b0001) begin failures++; $display("FAIL ssub_mask got=%b exp=0001", out_mask); end
    checks++; if (out_flags !== 4'b0100) begin failures++; $display("FAIL ssub_flags got=%b exp=0100", out_flags); end
    step();
  endtask

  task automatic test_reduce();
    out_ready = 1'b1;
    // lanes: 0011, 0010, 0110, 0010 -> C=1 Z=1 N=1 V=0
    drive(1'b1, 3'b111, 1'b0, 32'h44332211, 16'h2623, 4'h3);
    step();
    checks++; if (out_flags !== 4'b0111) begin failures++; $display("FAIL reduce_allz got=%b exp=0111", out_flags); end
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL reduce_data got=%h exp=44332211", out_data); end
    // lane 3 Z cleared -> Z=0
    drive(1'b1, 3'b111, 1'b0, 32'h0, 16'h0623, 4'h3);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (out_flags !== 4'b0101) begin failures++; $display("FAIL reduce_z_and got=%b exp=0101", out_flags); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 1'b0, 32'hA0A1A2A3, 16'h0, 4'h1);
    step();
    checks++; if ({out_valid, in_ready, out_dest} !== {1'b1, 1'b1, 4'h1}) begin failures++; $display("FAIL b2b_acc_a got=%b_%b_%h exp=1_1_1", out_valid, in_ready, out_dest); end
    drive(1'b1, 3'b010, 1'b0, 32'hB0B1B2B3, 16'h0, 4'h2);
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
    checks++; if (out_dest !== 4'h1) begin failures++; $display("FAIL b2b_head_a got=%h exp=1", out_dest); end
    drive(1'b1, 3'b010, 1'b0, 32'hC0C1C2C3, 16'h0, 4'h3);
    step();
    checks++; if ({in_ready, out_dest, out_data} !== {1'b0, 4'h1, 32'hA0A1A2A3}) begin failures++; $display("FAIL b2b_stall got=%b_%h_%h exp=0_1_a0a1a2a3", in_ready, out_dest, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if ({out_valid, out_dest, out_data} !== {1'b1, 4'h2, 32'hB0B1B2B3}) begin failures++; $display("FAIL b2b_emit_b got=%b_%h_%h exp=1_2_b0b1b2b3", out_valid, out_dest, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back got=%b exp=1", in_ready); end
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if ({out_valid, out_dest, out_data} !== {1'b1, 4'h3, 32'hC0C1C2C3}) begin failures++; $display("FAIL b2b_emit_c got=%b_%h_%h exp=1_3_c0c1c2c3", out_valid, out_dest, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_sticky_ovf();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'h01020304, 16'h0800, 4'h7);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (out_flags !== 4'b1000) begin failures++; $display("FAIL ovf_flags got=%b exp=1000", out_flags); end
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", sticky_ovf); end
    step();
    step();
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL ovf_persist got=%b exp=1", sticky_ovf); end
    drive(1'b1, 3'b000, 1'b0, 32'h0, 16'h0800, 4'h7);
    sticky_clr = 1'b1;
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", sticky_ovf); end
    step();
    sticky_clr = 1'b0;
    checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", sticky_ovf); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 1'b0, 32'h12345678, 16'hFFFF, 4'hA);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%b exp=1", out_valid); end
    checks++; if ({out_mask, out_flags} !== 8'h00) begin failures++; $display("FAIL ill_mask_flags got=%b_%b exp=0000_0000", out_mask, out_flags); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL ill_data got=%h exp=00000000", out_data); end
    checks++; if ({sticky_err, sticky_ovf} !== 2'b10) begin failures++; $display("FAIL ill_sticky got=%b exp=10", {sticky_err, sticky_ovf}); end
    step();
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    checks++; if (sticky_err !== 1'b0) begin failures++; $display("FAIL ill_clear got=%b exp=0", sticky_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 1'b0, 32'hDEADBEEF, 16'h0, 4'hD);
    step();
    drive(1'b1, 3'b010, 1'b0, 32'hCAFEF00D, 16'h0, 4'hE);
    step();
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL rmid_full got=%b exp=10", {out_valid, in_ready}); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rmid_async got=%b exp=01", {out_valid, in_ready}); end
    step();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({out_valid, out_data} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rmid_no_beat cyc=%0d got=%b_%h exp=0_00000000", i, out_valid, out_data); end
    end
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    drive(1'b0, 3'b010, 1'b0, 32'h0, 16'h0, 4'h0);
    test_reset();
    test_vector_add();
    test_scalar_sub();
    test_reduce();
    test_back_to_back();
    test_sticky_ovf();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
